cacheline_adapter: RTL
======================

# cacheline_adapter

Converts single-cycle 256-bit cache-line requests from the cache arbiter into 4-beat, 64-bit burst transactions on the physical memory port. It sits between the cache hierarchy inside `mp4` and the burst memory driving `pmem_*`. Its memory-side outputs are the top-level `pmem_read`, `pmem_write`, `pmem_address` and `pmem_wdata` seen by the bench and the RVFI monitor.

## Interface
Parameters:
- `LINE_W`, 256: cache line width in bits.
- `BURST_W`, 64: memory beat width in bits; beats per line `NBEATS = LINE_W/BURST_W` (4).
- `ADDR_W`, 32: address width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `line_i` in LINE_W: write-back line from the cache.
- `line_o` out LINE_W: assembled read line.
- `address_i` in ADDR_W: line address from the cache.
- `read_i` in 1: line read request, held until `resp_o`.
- `write_i` in 1: line write request, held until `resp_o`.
- `resp_o` out 1: one-cycle completion pulse.
- `burst_i` in BURST_W: memory read beat (`pmem_rdata`).
- `burst_o` out BURST_W: memory write beat (`pmem_wdata`).
- `address_o` out ADDR_W: burst base address (`pmem_address`).
- `read_o` out 1: `pmem_read`.
- `write_o` out 1: `pmem_write`.
- `resp_i` in 1: `pmem_resp`, one beat per high cycle.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - `write_i` high: latch `line_i` and the aligned address `{address_i[31:5],5'b0}`, clear the beat counter, go to WRITE.
  - Else `read_i` high: latch the aligned address, clear the counter, go to READ.
  - Write wins if both are high, which is illegal from the cache.
- READ:
  - `read_o`=1.
  - Each cycle with `resp_i`=1 stores `burst_i` into line slice `[64*cnt +: 64]` and increments `cnt`.
  - On the beat with `cnt`=3, go to DONE.
- WRITE:
  - `write_o`=1, `burst_o` = latched line slice `[64*cnt +: 64]`.
  - Each `resp_i` increments `cnt`.
  - On the beat with `cnt`=3, go to DONE.
- DONE:
  - `resp_o`=1 for exactly one cycle, then go to IDLE.
  - `read_i`/`write_i` are ignored in DONE. The cache drops its request in the cycle after `resp_o`; a request still high in IDLE starts a new transaction.
- `address_o` holds the latched address for the whole burst; it does not follow `address_i`.
- `line_o` holds the last assembled line until the next read completes. Write transactions do not alter it.
- `resp_i` is ignored in IDLE and DONE. Gaps between beats are allowed, and `cnt` advances only on `resp_i`.
- `cnt` is 2 bits and only ever counts to 3 within one burst.

## Timing
- Reset values: `resp_o`=0, `read_o`=0, `write_o`=0, `address_o`=0, `burst_o`=0, `line_o`=0; state IDLE, `cnt`=0.
- All outputs are registered or decoded from registered state only; there is no combinational path from `*_i` to `*_o`.
- Latency:
  - Request sampled in IDLE at edge 0; `read_o`/`write_o` high from cycle 1.
  - With beats at cycles k..k+3, `read_o`/`write_o` drop and `resp_o`=1 in cycle k+4.
  - Best case (k=1): request to `resp_o` is 5 cycles.
- `read_o`/`write_o` stay high continuously from cycle 1 through the final beat cycle. They never toggle mid-burst.
- `burst_o` updates the cycle after each accepted write beat. It is stable while `resp_i`=0.
- Reset mid-burst:
  - The FSM returns to IDLE at that edge; `read_o`/`write_o` are 0 the next cycle.
  - The partial line is discarded, `line_o` is cleared, and no `resp_o` is issued.

## Structure
- Package `cacheline_pkg`: `LINE_W`, `BURST_W`, `NBEATS`, the offset width (5), the `adapter_state_t` enum, and the line/beat typedefs.
- Single module. The beat counter and shift/slice logic stay inline; no sub-module is warranted.

## Test plan
- Read: `read_i`, `address_i`=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive cycles.
  - Expect `address_o`=0x0000_1220 and `read_o` high exactly 4 cycles.
  - Expect `line_o`=0x44..44_33..33_22..22_11..11 and `resp_o` one pulse, 5 cycles after the request.
- Write: `line_i`=0xDDDD..._CCCC..._BBBB..._AAAA..., `write_i`.
  - Expect `burst_o` sequence 0xAAAA.., 0xBBBB.., 0xCCCC.., 0xDDDD.. on successive `resp_i`; `write_o` never toggles; one `resp_o`.
  - Expect `line_o` unchanged from the prior read.
- Gapped read: `resp_i` pattern 1,0,0,1,1,0,1.
  - Expect the correct 4-beat assembly and `resp_o` the cycle after the last 1.
  - Expect `address_o` stable despite `address_i` changing mid-burst.
- Both `read_i` and `write_i` high in IDLE: expect a WRITE burst (`write_o`=1, `read_o`=0).
- Back-to-back: the cache re-asserts `read_i` the cycle after `resp_o`. Expect IDLE for one cycle, then a new `read_o` the following cycle, with no extra `resp_o`.
- Reset asserted after beat 2 of a read: expect `read_o`=0 next cycle, `line_o`=0, no `resp_o`; a subsequent read completes normally.

Source files
------------

// File: rtl/cacheline_pkg.sv
// Shared constants and types for the cache-line to memory-burst adapter.
// The state enum is shared so the bench can name the debug state output.
package cacheline_pkg;

  localparam int LINE_W   = 256;
  localparam int BURST_W  = 64;
  localparam int ADDR_W   = 32;
  localparam int NBEATS   = LINE_W / BURST_W;
  localparam int OFFSET_W = 5;
  localparam int CNT_W    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adapter_state_t;

  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [BURST_W-1:0] beat_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Splits 256-bit cache-line reads/writes into 4-beat 64-bit memory bursts.
// Every output is decoded from registered state; no input reaches an output combinationally.
module cacheline_adapter
  import cacheline_pkg::*;
#(
  parameter int LINE_W  = cacheline_pkg::LINE_W,
  parameter int BURST_W = cacheline_pkg::BURST_W,
  parameter int ADDR_W  = cacheline_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LINE_W-1:0]    line_i,
  output logic [LINE_W-1:0]    line_o,
  input  logic [ADDR_W-1:0]    address_i,
  input  logic                 read_i,
  input  logic                 write_i,
  output logic                 resp_o,
  input  logic [BURST_W-1:0]   burst_i,
  output logic [BURST_W-1:0]   burst_o,
  output logic [ADDR_W-1:0]    address_o,
  output logic                 read_o,
  output logic                 write_o,
  input  logic                 resp_i,
  output adapter_state_t       state_o
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_W / BURST_W - 1);

  adapter_state_t      state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wline_q, wline_d;
  logic [LINE_W-1:0]   rbuf_q, rbuf_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [ADDR_W-1:0]   aligned_addr;

  assign aligned_addr = {address_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rbuf_d  = rbuf_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        // Write has priority if the cache ever raises both requests.
        if (write_i) begin
          wline_d = line_i;
          addr_d  = aligned_addr;
          cnt_d   = '0;
          state_d = WRITE;
        end else if (read_i) begin
          addr_d  = aligned_addr;
          cnt_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (resp_i) begin
          rbuf_d[BURST_W*cnt_q +: BURST_W] = burst_i;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            // line_o only changes once a full line has been assembled.
            line_d  = rbuf_d;
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        if (resp_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rbuf_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rbuf_q  <= rbuf_d;
      line_q  <= line_d;
    end
  end

  assign read_o    = (state_q == READ);
  assign write_o   = (state_q == WRITE);
  assign resp_o    = (state_q == DONE);
  assign address_o = addr_q;
  assign line_o    = line_q;
  assign burst_o   = wline_q[BURST_W*cnt_q +: BURST_W];
  assign state_o   = state_q;

endmodule
